memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory bus between the instruction-fetch port
// and the MEM-stage data port. Only one bus transfer can be outstanding.
// When both ports request at once, the port that was not served last wins.
module memory_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_read_enable,
    input  logic [31:0] inst_read_address,
    output logic [31:0] inst_read_data,
    output logic        inst_ready,
    input  logic        data_read_enable,
    input  logic [31:0] data_read_address,
    output logic [31:0] data_read_data,
    input  logic        data_write_enable,
    input  logic [31:0] data_write_address,
    input  logic [3:0]  data_write_select,
    input  logic [31:0] data_write_data,
    output logic        data_ready,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_select,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_acknowledge,
    output logic        stall_request
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_INST} state_t;
    typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

    state_t      state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ready_q, inst_ready_d;
    logic        data_ready_q, data_ready_d;

    logic        data_pending, inst_pending;
    logic        data_req, inst_req;
    logic        grant_data, grant_inst;

    assign data_pending = data_read_enable | data_write_enable;
    assign inst_pending = inst_read_enable;

    // A requester in its ready cycle has just been served; its still-high
    // enable must not start a second transfer.
    assign data_req = data_pending & ~data_ready_q;
    assign inst_req = inst_pending & ~inst_ready_q;

    // State, transfer and read-data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_INST;
            write_q      <= 1'b0;
            addr_q       <= '0;
            sel_q        <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
        end
    end

    // Arbitration, transfer capture and completion handling.
    // The transfer registers are cleared on completion so that the bus
    // outputs read as zero whenever the arbiter is idle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        grant_data   = 1'b0;
        grant_inst   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_data = data_req & (~inst_req | (last_grant_q == GRANT_INST));
                grant_inst = inst_req & ~grant_data;
                if (grant_data) begin
                    state_d = ST_DATA;
                    if (data_write_enable) begin
                        write_d = 1'b1;
                        addr_d  = data_write_address;
                        sel_d   = data_write_select;
                        wdata_d = data_write_data;
                    end else begin
                        write_d = 1'b0;
                        addr_d  = data_read_address;
                        sel_d   = '1;
                        wdata_d = '0;
                    end
                end else if (grant_inst) begin
                    state_d = ST_INST;
                    write_d = 1'b0;
                    addr_d  = inst_read_address;
                    sel_d   = '1;
                    wdata_d = '0;
                end
            end
            ST_DATA, ST_INST: begin
                if (bus_acknowledge) begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                    addr_d  = '0;
                    sel_d   = '0;
                    wdata_d = '0;
                    if (state_q == ST_DATA) begin
                        last_grant_d = GRANT_DATA;
                        data_ready_d = 1'b1;
                        if (!write_q) begin
                            data_rdata_d = bus_read_data;
                        end
                    end else begin
                        last_grant_d = GRANT_INST;
                        inst_ready_d = 1'b1;
                        inst_rdata_d = bus_read_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_request    = (state_q != ST_IDLE);
    assign bus_write      = write_q;
    assign bus_address    = addr_q;
    assign bus_select     = sel_q;
    assign bus_write_data = wdata_q;
    assign inst_read_data = inst_rdata_q;
    assign data_read_data = data_rdata_q;
    assign inst_ready     = inst_ready_q;
    assign data_ready     = data_ready_q;
    assign stall_request  = (data_pending & ~data_ready_q) | (inst_pending & ~inst_ready_q);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios with literal expectations, followed
// by randomized traffic checked every cycle against a transaction-level model.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_read_enable;
    logic [31:0] inst_read_address;
    logic [31:0] inst_read_data;
    logic        inst_ready;
    logic        data_read_enable;
    logic [31:0] data_read_address;
    logic [31:0] data_read_data;
    logic        data_write_enable;
    logic [31:0] data_write_address;
    logic [3:0]  data_write_select;
    logic [31:0] data_write_data;
    logic        data_ready;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;
    logic        stall_request;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    memory_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .inst_read_enable   (inst_read_enable),
        .inst_read_address  (inst_read_address),
        .inst_read_data     (inst_read_data),
        .inst_ready         (inst_ready),
        .data_read_enable   (data_read_enable),
        .data_read_address  (data_read_address),
        .data_read_data     (data_read_data),
        .data_write_enable  (data_write_enable),
        .data_write_address (data_write_address),
        .data_write_select  (data_write_select),
        .data_write_data    (data_write_data),
        .data_ready         (data_ready),
        .bus_request        (bus_request),
        .bus_write          (bus_write),
        .bus_address        (bus_address),
        .bus_select         (bus_select),
        .bus_write_data     (bus_write_data),
        .bus_read_data      (bus_read_data),
        .bus_acknowledge    (bus_acknowledge),
        .stall_request      (stall_request)
    );

    always #5 clock = ~clock;

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic        valid;   // a transfer is on the bus
        logic        is_data; // owner
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } txn_t;

    txn_t        m_txn;
    logic        m_valid = 1'b0;   // model has seen a reset
    logic        m_last_was_data;
    logic [31:0] m_inst_rd, m_data_rd;
    logic        m_inst_rdy, m_data_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        logic exp_stall;
        if (m_valid) begin
            exp_stall = ((data_read_enable | data_write_enable) & ~m_data_rdy)
                      | (inst_read_enable & ~m_inst_rdy);
            chk("bus_request",    {31'd0, bus_request},    {31'd0, m_txn.valid});
            chk("bus_write",      {31'd0, bus_write},      {31'd0, m_txn.valid & m_txn.wr});
            chk("bus_address",    bus_address,             m_txn.valid ? m_txn.addr : 32'd0);
            chk("bus_select",     {28'd0, bus_select},     {28'd0, m_txn.valid ? m_txn.sel : 4'd0});
            chk("bus_write_data", bus_write_data,          m_txn.valid ? m_txn.wdata : 32'd0);
            chk("inst_ready",     {31'd0, inst_ready},     {31'd0, m_inst_rdy});
            chk("data_ready",     {31'd0, data_ready},     {31'd0, m_data_rdy});
            chk("inst_read_data", inst_read_data,          m_inst_rd);
            chk("data_read_data", data_read_data,          m_data_rd);
            chk("stall_request",  {31'd0, stall_request},  {31'd0, exp_stall});
        end
    endtask

    // Advance the model by one clock edge using the inputs applied now.
    task automatic model_edge();
        logic want_d, want_i, pick_d;
        if (reset) begin
            m_valid         = 1'b1;
            m_txn.valid     = 1'b0;
            m_last_was_data = 1'b0;
            m_inst_rd       = '0;
            m_data_rd       = '0;
            m_inst_rdy      = 1'b0;
            m_data_rdy      = 1'b0;
        end else if (m_valid) begin
            if (m_txn.valid) begin
                m_inst_rdy = 1'b0;
                m_data_rdy = 1'b0;
                if (bus_acknowledge) begin
                    m_txn.valid     = 1'b0;
                    m_last_was_data = m_txn.is_data;
                    if (m_txn.is_data) begin
                        m_data_rdy = 1'b1;
                        if (!m_txn.wr) m_data_rd = bus_read_data;
                    end else begin
                        m_inst_rdy = 1'b1;
                        m_inst_rd  = bus_read_data;
                    end
                end
            end else begin
                want_d = (data_read_enable | data_write_enable) & ~m_data_rdy;
                want_i = inst_read_enable & ~m_inst_rdy;
                m_inst_rdy = 1'b0;
                m_data_rdy = 1'b0;
                pick_d = want_d & (!want_i || !m_last_was_data);
                if (pick_d) begin
                    m_txn.valid   = 1'b1;
                    m_txn.is_data = 1'b1;
                    m_txn.wr      = data_write_enable;
                    m_txn.addr    = data_write_enable ? data_write_address : data_read_address;
                    m_txn.sel     = data_write_enable ? data_write_select : 4'hF;
                    m_txn.wdata   = data_write_enable ? data_write_data : 32'd0;
                end else if (want_i) begin
                    m_txn.valid   = 1'b1;
                    m_txn.is_data = 1'b0;
                    m_txn.wr      = 1'b0;
                    m_txn.addr    = inst_read_address;
                    m_txn.sel     = 4'hF;
                    m_txn.wdata   = 32'd0;
                end
            end
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1ns later.
    task automatic step();
        #1;
        compare_model();
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        inst_read_enable   = 1'b0;
        inst_read_address  = '0;
        data_read_enable   = 1'b0;
        data_read_address  = '0;
        data_write_enable  = 1'b0;
        data_write_address = '0;
        data_write_select  = '0;
        data_write_data    = '0;
        bus_read_data      = '0;
        bus_acknowledge    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state.
        chk("rst_bus_request", {31'd0, bus_request}, 32'd0);
        chk("rst_bus_address", bus_address, 32'd0);
        chk("rst_data_rd", data_read_data, 32'd0);
        chk("rst_inst_rd", inst_read_data, 32'd0);

        // Data read, one-cycle ack, 3-cycle latency, enable held through ready.
        data_read_enable = 1'b1;
        data_read_address = 32'h0000_0010;
        #1 chk("rd_stall_c0", {31'd0, stall_request}, 32'd1);
        step();
        chk("rd_req_c1", {31'd0, bus_request}, 32'd1);
        chk("rd_addr_c1", bus_address, 32'h0000_0010);
        chk("rd_sel_c1", {28'd0, bus_select}, 32'hF);
        bus_acknowledge = 1'b1;
        bus_read_data = 32'hDEAD_BEEF;
        step();
        bus_acknowledge = 1'b0;
        chk("rd_ready_c2", {31'd0, data_ready}, 32'd1);
        chk("rd_data_c2", data_read_data, 32'hDEAD_BEEF);
        #1 chk("rd_stall_c2", {31'd0, stall_request}, 32'd0);
        step();
        data_read_enable = 1'b0;
        chk("rd_single_txn", {31'd0, bus_request}, 32'd0);
        chk("rd_ready_once", {31'd0, data_ready}, 32'd0);
        step();

        // Write with simultaneous read, 4 wait cycles.
        data_write_enable = 1'b1;
        data_read_enable = 1'b1;
        data_write_address = 32'h20;
        data_read_address = 32'h44;
        data_write_select = 4'b0011;
        data_write_data = 32'h0000_ABCD;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wr_write", {31'd0, bus_write}, 32'd1);
            chk("wr_addr", bus_address, 32'h20);
            chk("wr_sel", {28'd0, bus_select}, 32'h3);
            chk("wr_wdata", bus_write_data, 32'h0000_ABCD);
            bus_acknowledge = (i == 4);
            bus_read_data = 32'h5555_5555;
            step();
        end
        bus_acknowledge = 1'b0;
        chk("wr_ready", {31'd0, data_ready}, 32'd1);
        chk("wr_keeps_rd", data_read_data, 32'hDEAD_BEEF);
        data_write_enable = 1'b0;
        data_read_enable = 1'b0;
        step();

        // Ties from reset: data first, then alternating.
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_read_enable = 1'b1;
        data_read_address = 32'h100;
        inst_read_enable = 1'b1;
        inst_read_address = 32'h200;
        step();
        chk("tie1_data", bus_address, 32'h100);
        bus_acknowledge = 1'b1;
        bus_read_data = 32'h1111_1111;
        step();
        bus_acknowledge = 1'b0;
        chk("tie1_dready", {31'd0, data_ready}, 32'd1);
        step();
        chk("tie1_then_inst", bus_address, 32'h200);
        bus_acknowledge = 1'b1;
        bus_read_data = 32'h2222_2222;
        step();
        bus_acknowledge = 1'b0;
        chk("tie1_iready", {31'd0, inst_ready}, 32'd1);
        chk("tie1_irdata", inst_read_data, 32'h2222_2222);
        data_read_enable = 1'b0;
        inst_read_enable = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            data_read_enable = 1'b1;
            inst_read_enable = 1'b1;
            step();
            chk("tie_alt", bus_address, (k == 0) ? 32'h100 : 32'h200);
            bus_acknowledge = 1'b1;
            step();
            bus_acknowledge = 1'b0;
            data_read_enable = 1'b0;
            inst_read_enable = 1'b0;
            step();
        end

        // Fetch with 3 wait cycles: stall until the ready cycle.
        inst_read_enable = 1'b1;
        inst_read_address = 32'h0040_0000;
        #1 chk("f_stall_c0", {31'd0, stall_request}, 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("f_addr", bus_address, 32'h0040_0000);
            bus_acknowledge = (i == 3);
            bus_read_data = 32'hCAFE_0001;
            #1 chk("f_stall", {31'd0, stall_request}, 32'd1);
            step();
        end
        bus_acknowledge = 1'b0;
        #1 chk("f_ready", {31'd0, inst_ready}, 32'd1);
        chk("f_stall_ready", {31'd0, stall_request}, 32'd0);
        step();
        inst_read_enable = 1'b0;
        step();

        // Reset during a data transfer abandons it; later ack is ignored.
        data_read_enable = 1'b1;
        data_read_address = 32'h30;
        step();
        chk("ab_req", {31'd0, bus_request}, 32'd1);
        reset = 1'b1;
        data_read_enable = 1'b0;
        step();
        reset = 1'b0;
        chk("ab_req_off", {31'd0, bus_request}, 32'd0);
        chk("ab_addr_zero", bus_address, 32'd0);
        chk("ab_rd_zero", data_read_data, 32'd0);
        bus_acknowledge = 1'b1;
        step();
        bus_acknowledge = 1'b0;
        chk("ab_no_ready", {31'd0, data_ready}, 32'd0);
        chk("ab_still_idle", {31'd0, bus_request}, 32'd0);
        step();

        // Randomized traffic, including acks in idle and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset              = ($urandom_range(0, 199) == 0);
            inst_read_enable   = ($urandom_range(0, 2) != 0);
            inst_read_address  = $urandom;
            data_read_enable   = ($urandom_range(0, 1) != 0);
            data_read_address  = $urandom;
            data_write_enable  = ($urandom_range(0, 3) == 0);
            data_write_address = $urandom;
            data_write_select  = 4'($urandom);
            data_write_data    = $urandom;
            bus_read_data      = $urandom;
            bus_acknowledge    = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
